// File: rtl/vend_ctrl_multi_if.sv
// Signal bundle between the coin/keypad/restock front end (master) and vend_ctrl_multi (slave).
interface vend_ctrl_multi_if #(
    parameter int N_ITEMS  = 4,
    parameter int PRICE_W  = 8,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W  = 6,
    parameter int QTY_W    = 2
);
    localparam int IDX_W = $clog2(N_ITEMS);

    logic                         coin_valid;
    logic [1:0]                   coin_type;
    logic                         coin_reject;
    logic                         sel_valid;
    logic [IDX_W-1:0]             sel_item;
    logic [QTY_W-1:0]             sel_qty;
    logic                         cancel;
    logic [N_ITEMS*PRICE_W-1:0]   price_flat;
    logic                         stock_load;
    logic [IDX_W-1:0]             stock_load_item;
    logic [STOCK_W-1:0]           stock_load_val;
    logic [N_ITEMS*STOCK_W-1:0]   stock_flat;
    logic [CREDIT_W-1:0]          credit;
    logic                         vend_valid;
    logic [IDX_W-1:0]             vend_item;
    logic [QTY_W-1:0]             vend_qty;
    logic                         change_valid;
    logic [1:0]                   change_coin;
    logic [1:0]                   err;
    logic                         busy;

    modport master (
        output coin_valid, coin_type, sel_valid, sel_item, sel_qty, cancel, price_flat,
               stock_load, stock_load_item, stock_load_val,
        input  coin_reject, stock_flat, credit, vend_valid, vend_item, vend_qty,
               change_valid, change_coin, err, busy
    );

    modport slave (
        input  coin_valid, coin_type, sel_valid, sel_item, sel_qty, cancel, price_flat,
               stock_load, stock_load_item, stock_load_val,
        output coin_reject, stock_flat, credit, vend_valid, vend_item, vend_qty,
               change_valid, change_coin, err, busy
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-coin, multi-item vending controller: running credit, per-item stock, greedy 20/10/5 change.
module vend_ctrl_multi #(
    parameter int N_ITEMS  = 4,
    parameter int PRICE_W  = 8,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W  = 6,
    parameter int QTY_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    vend_ctrl_multi_if.slave  bus
);
    localparam int IDX_W  = $clog2(N_ITEMS);
    localparam int COST_W = PRICE_W + QTY_W;
    localparam int CW1    = CREDIT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;
    state_t r_state, w_next;

    logic [CREDIT_W-1:0]             r_credit;
    logic [N_ITEMS-1:0][STOCK_W-1:0] r_stock;
    logic [IDX_W-1:0]                r_item;
    logic [QTY_W-1:0]                r_qty;
    logic [CREDIT_W-1:0]             r_cost;
    logic                            r_reject;
    logic [1:0]                      r_err;

    logic [PRICE_W-1:0]  w_price [N_ITEMS];
    logic [CW1-1:0]      w_coin_amt, w_sum;
    logic                w_coin_ok, w_item_ok, w_load_ok;
    logic [IDX_W-1:0]    w_idx;
    logic [COST_W-1:0]   w_cost;
    logic [1:0]          w_sel_err;
    logic [CREDIT_W-1:0] w_chg_amt, w_after_vend, w_after_chg;
    logic [1:0]          w_chg_code;
    logic                w_take_coin, w_take_sel;

    // Coin decode; the extra sum bit flags a credit overflow.
    always_comb begin
        case (bus.coin_type)
            2'd0:    w_coin_amt = CW1'(5);
            2'd1:    w_coin_amt = CW1'(10);
            2'd2:    w_coin_amt = CW1'(20);
            default: w_coin_amt = '0;
        endcase
        w_sum     = {1'b0, r_credit} + w_coin_amt;
        w_coin_ok = bus.coin_valid && (bus.coin_type != 2'd3) && !w_sum[CREDIT_W];
    end

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) w_price[i] = bus.price_flat[i*PRICE_W +: PRICE_W];
    end

    // Selection checks, in priority order: bad select, no stock, low credit.
    always_comb begin
        w_item_ok = 32'(bus.sel_item) < N_ITEMS;
        w_idx     = w_item_ok ? bus.sel_item : '0;
        w_cost    = COST_W'(w_price[w_idx]) * COST_W'(bus.sel_qty);
        if (r_state == S_IDLE)                                 w_sel_err = 2'd1;
        else if (!w_item_ok || bus.sel_qty == '0)              w_sel_err = 2'd3;
        else if (32'(r_stock[w_idx]) < 32'(bus.sel_qty))       w_sel_err = 2'd2;
        else if (32'(r_credit) < 32'(w_cost))                  w_sel_err = 2'd1;
        else                                                   w_sel_err = 2'd0;
    end

    always_comb begin
        if (r_credit >= CREDIT_W'(20)) begin
            w_chg_amt = CREDIT_W'(20); w_chg_code = 2'd2;
        end else if (r_credit >= CREDIT_W'(10)) begin
            w_chg_amt = CREDIT_W'(10); w_chg_code = 2'd1;
        end else begin
            w_chg_amt = CREDIT_W'(5);  w_chg_code = 2'd0;
        end
        w_after_chg  = r_credit - w_chg_amt;
        w_after_vend = r_credit - r_cost;
        w_load_ok    = bus.stock_load && (32'(bus.stock_load_item) < N_ITEMS) && (r_state != S_VEND);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Cancel only matters with credit held; the losing coin in a sel/cancel cycle is rejected.
    always_comb begin
        w_next      = r_state;
        w_take_coin = 1'b0;
        w_take_sel  = 1'b0;
        case (r_state)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel && r_state == S_CREDIT) begin
                    w_next = S_CHANGE;
                end else if (bus.sel_valid) begin
                    w_take_sel = 1'b1;
                    if (w_sel_err == 2'd0) w_next = S_VEND;
                end else if (w_coin_ok) begin
                    w_take_coin = 1'b1;
                    w_next      = S_CREDIT;
                end
            end
            S_VEND:   w_next = (w_after_vend >= CREDIT_W'(5)) ? S_CHANGE : S_IDLE;
            S_CHANGE: w_next = (w_after_chg  >= CREDIT_W'(5)) ? S_CHANGE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= '0;
            r_stock  <= '0;
            r_item   <= '0;
            r_qty    <= '0;
            r_cost   <= '0;
            r_reject <= 1'b0;
            r_err    <= 2'd0;
        end else begin
            r_reject <= bus.coin_valid && !w_take_coin;
            r_err    <= w_take_sel ? w_sel_err : 2'd0;
            case (r_state)
                S_IDLE, S_CREDIT: begin
                    if (w_take_coin) r_credit <= w_sum[CREDIT_W-1:0];
                    if (w_take_sel && w_sel_err == 2'd0) begin
                        r_item <= bus.sel_item;
                        r_qty  <= bus.sel_qty;
                        r_cost <= CREDIT_W'(w_cost);  // fits: cost <= credit was checked
                    end
                end
                S_VEND: begin
                    r_credit        <= (w_after_vend >= CREDIT_W'(5)) ? w_after_vend : '0;
                    r_stock[r_item] <= r_stock[r_item] - STOCK_W'(r_qty);
                end
                S_CHANGE: r_credit <= (w_after_chg >= CREDIT_W'(5)) ? w_after_chg : '0;
                default:  r_credit <= '0;
            endcase
            if (w_load_ok) r_stock[bus.stock_load_item] <= bus.stock_load_val;
        end
    end

    always_comb begin
        bus.vend_valid   = (r_state == S_VEND);
        bus.vend_item    = (r_state == S_VEND) ? r_item : '0;
        bus.vend_qty     = (r_state == S_VEND) ? r_qty : '0;
        bus.change_valid = (r_state == S_CHANGE);
        bus.change_coin  = (r_state == S_CHANGE) ? w_chg_code : 2'd0;
        bus.busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
        bus.credit       = r_credit;
        bus.coin_reject  = r_reject;
        bus.err          = r_err;
        bus.stock_flat   = r_stock;
    end
endmodule
